// File: rtl/lcg_pkg.sv
// lcg_pkg: shared types and the LCG step function for the 8-bit LCG
// generator/checker pair. f(x) = x + (x << r) + b, all modulo 2^8.
package lcg_pkg;

    localparam int LCG_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2,
        LOST   = 2'd3
    } state_t;

    // One LCG step; carries and shifted-out bits are dropped by the 8-bit width.
    function automatic logic [LCG_W-1:0] lcg_next(
        input logic [LCG_W-1:0] x,
        input logic [2:0]       r,
        input logic [LCG_W-1:0] b
    );
        logic [LCG_W-1:0] shifted;
        shifted  = x << r;
        lcg_next = x + shifted + b;
    endfunction

endpackage

// File: rtl/lcg_checker_step.sv
// lcg_step: purely combinational single-step predictor. Shared with the
// generator so both ends use the identical recurrence.
module lcg_step
    import lcg_pkg::*;
(
    input  logic [LCG_W-1:0] x,
    input  logic [2:0]       r,
    input  logic [LCG_W-1:0] b,
    output logic [LCG_W-1:0] y
);

    // Next word of the sequence following x.
    always_comb begin
        y = lcg_next(x, r, b);
    end

endmodule

// File: rtl/lcg_checker.sv
// lcg_checker: receive-side checker for the 8-bit LCG stream. Predicts each
// word, acquires lock after LOCK_N consecutive hits, counts matches/errors
// while locked (saturating), and flags loss after LOSS_N consecutive misses.
// Build option: define LCG_CHK_RESYNC_EN to re-acquire directly on loss
// (lost tied low); otherwise loss parks in LOST until start.
module lcg_checker
    import lcg_pkg::*;
#(
    parameter int LOCK_N = 4,
    parameter int LOSS_N = 3,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       r,
    input  logic [LCG_W-1:0] b,
    input  logic [LCG_W-1:0] x0,
    input  logic             in_valid,
    input  logic [LCG_W-1:0] in_data,
    output logic             locked,
    output logic             lost,
    output logic             err_pulse,
    output logic [LCG_W-1:0] expected,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [3:0] LOCK_V = 4'(LOCK_N);
    localparam logic [3:0] LOSS_V = 4'(LOSS_N);

    state_t           state, state_nxt;
    logic [2:0]       r_q, r_nxt;
    logic [LCG_W-1:0] b_q, b_nxt;
    logic [3:0]       run, run_nxt;
    logic [3:0]       miss, miss_nxt;
    logic [LCG_W-1:0] exp_nxt;
    logic [CNT_W-1:0] mc_nxt, ec_nxt;
    logic             errp_nxt;
    logic             hit;

    // Reseed unit: on start it predicts from x0 with the new config,
    // otherwise from the received word with the stored config.
    logic [LCG_W-1:0] seed_x, seed_b, reseed, fly;
    logic [2:0]       seed_r;

    always_comb begin
        seed_x = start ? x0 : in_data;
        seed_r = start ? r  : r_q;
        seed_b = start ? b  : b_q;
    end

    lcg_step u_reseed (
        .x (seed_x),
        .r (seed_r),
        .b (seed_b),
        .y (reseed)
    );

    // Flywheel unit: advances the current prediction without trusting input.
    lcg_step u_fly (
        .x (expected),
        .r (r_q),
        .b (b_q),
        .y (fly)
    );

    // Next-state and next-output logic; priority start > in_valid.
    always_comb begin
        state_nxt = state;
        r_nxt     = r_q;
        b_nxt     = b_q;
        run_nxt   = run;
        miss_nxt  = miss;
        exp_nxt   = expected;
        mc_nxt    = match_count;
        ec_nxt    = err_count;
        errp_nxt  = 1'b0;
        hit       = (in_data == expected);

        if (start) begin
            state_nxt = ACQ;
            r_nxt     = r;
            b_nxt     = b;
            run_nxt   = '0;
            miss_nxt  = '0;
            exp_nxt   = reseed;
            mc_nxt    = '0;
            ec_nxt    = '0;
        end else if (in_valid) begin
            unique case (state)
                ACQ: begin
                    // Self-reseed from the received word either way.
                    exp_nxt = reseed;
                    if (hit) begin
                        run_nxt = run + 4'd1;
                        if (run + 4'd1 == LOCK_V) begin
                            state_nxt = LOCKED;
                            run_nxt   = '0;
                            miss_nxt  = '0;
                        end
                    end else begin
                        run_nxt = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: a bad word never steers the prediction.
                    exp_nxt = fly;
                    if (hit) begin
                        miss_nxt = '0;
                        if (match_count != '1) mc_nxt = match_count + CNT_W'(1);
                    end else begin
                        errp_nxt = 1'b1;
                        miss_nxt = miss + 4'd1;
                        if (err_count != '1) ec_nxt = err_count + CNT_W'(1);
                        if (miss + 4'd1 == LOSS_V) begin
`ifdef LCG_CHK_RESYNC_EN
                            state_nxt = ACQ;
                            exp_nxt   = reseed;
                            run_nxt   = '0;
                            miss_nxt  = '0;
`else
                            state_nxt = LOST;
`endif
                        end
                    end
                end
                default: ;  // IDLE and LOST ignore samples
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            r_q         <= '0;
            b_q         <= '0;
            run         <= '0;
            miss        <= '0;
            expected    <= '0;
            match_count <= '0;
            err_count   <= '0;
            err_pulse   <= 1'b0;
            locked      <= 1'b0;
        end else begin
            state       <= state_nxt;
            r_q         <= r_nxt;
            b_q         <= b_nxt;
            run         <= run_nxt;
            miss        <= miss_nxt;
            expected    <= exp_nxt;
            match_count <= mc_nxt;
            err_count   <= ec_nxt;
            err_pulse   <= errp_nxt;
            locked      <= (state_nxt == LOCKED);
        end
    end

`ifdef LCG_CHK_RESYNC_EN
    assign lost = 1'b0;
`else
    // LOST flag, registered alongside locked.
    always_ff @(posedge clk) begin
        if (reset) lost <= 1'b0;
        else       lost <= (state_nxt == LOST);
    end
`endif

endmodule

// File: tb/tb_lcg_checker.sv
// tb_lcg_checker: table-driven directed vectors plus randomized streams
// checked against an arithmetic reference model; a second instance with
// CNT_W=2 exercises counter saturation.
module tb_lcg_checker;

    localparam int LOCK_N = 4;
    localparam int LOSS_N = 3;
    localparam int M_IDLE = 0, M_ACQ = 1, M_LOCKED = 2, M_LOST = 3;

    logic       clk = 1'b0;
    logic       reset, start, in_valid;
    logic [2:0] r;
    logic [7:0] b, x0, in_data;

    logic        locked, lost, err_pulse;
    logic [7:0]  expected;
    logic [15:0] match_count, err_count;
    logic        locked2, lost2, err_pulse2;
    logic [7:0]  expected2;
    logic [1:0]  match_count2, err_count2;

    always #5 clk = ~clk;

    lcg_checker #(.LOCK_N(LOCK_N), .LOSS_N(LOSS_N), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .r(r), .b(b), .x0(x0),
        .in_valid(in_valid), .in_data(in_data), .locked(locked), .lost(lost),
        .err_pulse(err_pulse), .expected(expected),
        .match_count(match_count), .err_count(err_count));

    lcg_checker #(.LOCK_N(LOCK_N), .LOSS_N(LOSS_N), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .r(r), .b(b), .x0(x0),
        .in_valid(in_valid), .in_data(in_data), .locked(locked2), .lost(lost2),
        .err_pulse(err_pulse2), .expected(expected2),
        .match_count(match_count2), .err_count(err_count2));

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state (plain integers, unbounded counters).
    int m_mode, m_r, m_b, m_exp, m_run, m_miss, m_mc, m_ec;
    bit m_errp;

    function automatic int f(input int x, input int rr, input int bb);
        return (x + x * (2 ** rr) + bb) % 256;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic check(input string name, input int act, input int want);
        n_checks++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d want %0d", name, act, want);
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_r = 0; m_b = 0; m_exp = 0;
        m_run = 0; m_miss = 0; m_mc = 0; m_ec = 0; m_errp = 0;
    endtask

    task automatic model_step(input bit st, input int rr, input int bb, input int xx,
                              input bit v, input int d);
        m_errp = 0;
        if (st) begin
            m_mode = M_ACQ; m_r = rr; m_b = bb; m_exp = f(xx, rr, bb);
            m_run = 0; m_miss = 0; m_mc = 0; m_ec = 0;
        end else if (v && m_mode == M_ACQ) begin
            m_run = (d == m_exp) ? m_run + 1 : 0;
            m_exp = f(d, m_r, m_b);
            if (m_run == LOCK_N) begin
                m_mode = M_LOCKED; m_run = 0; m_miss = 0;
            end
        end else if (v && m_mode == M_LOCKED) begin
            if (d == m_exp) begin
                m_mc++; m_miss = 0;
            end else begin
                m_ec++; m_miss++; m_errp = 1;
            end
            m_exp = f(m_exp, m_r, m_b);
            if (m_miss == LOSS_N) begin
`ifdef LCG_CHK_RESYNC_EN
                m_mode = M_ACQ; m_exp = f(d, m_r, m_b); m_run = 0; m_miss = 0;
`else
                m_mode = M_LOST;
`endif
            end
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".locked"},    int'(locked),      int'(m_mode == M_LOCKED));
        check({tag, ".lost"},      int'(lost),        int'(m_mode == M_LOST));
        check({tag, ".err_pulse"}, int'(err_pulse),   int'(m_errp));
        check({tag, ".expected"},  int'(expected),    m_exp);
        check({tag, ".match"},     int'(match_count), sat(m_mc, 65535));
        check({tag, ".errcnt"},    int'(err_count),   sat(m_ec, 65535));
        check({tag, ".match2"},    int'(match_count2), sat(m_mc, 3));
        check({tag, ".errcnt2"},   int'(err_count2),   sat(m_ec, 3));
        check({tag, ".locked2"},   int'(locked2),     int'(m_mode == M_LOCKED));
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model,
    // then compare after the rising edge at the next falling edge.
    task automatic cycle(input bit st, input int rr, input int bb, input int xx,
                         input bit v, input int d, input string tag);
        start = st; r = 3'(rr); b = 8'(bb); x0 = 8'(xx);
        in_valid = v; in_data = 8'(d);
        model_step(st, rr, bb, xx, v, d);
        @(negedge clk);
        compare_model(tag);
    endtask

    typedef struct {
        bit st; int x0; bit v; int d;
        bit e_lk; bit e_lost; bit e_err; int e_exp; int e_mc; int e_ec;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit st, int xx, bit v, int d, bit lk, bit ls,
                                bit er, int ex, int mc, int ec);
        vec_t t;
        t.st = st; t.x0 = xx; t.v = v; t.d = d;
        t.e_lk = lk; t.e_lost = ls; t.e_err = er; t.e_exp = ex; t.e_mc = mc; t.e_ec = ec;
        return t;
    endfunction

    initial begin
        int gen, corrupt_pct, rr, bb, xx, d;
        bit v;

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; r = '0; b = '0; x0 = '0; in_data = '0;
        model_reset();
        // Reset for two cycles with random inputs.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            start = 1'($urandom); in_valid = 1'($urandom);
            r = 3'($urandom); b = 8'($urandom); x0 = 8'($urandom); in_data = 8'($urandom);
        end
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        compare_model("reset");
        reset = 1'b0;

        // Directed table, r=1 b=3 so f(x) = 3x+3 mod 256.
        vecs.push_back(mk(1, 5, 0, 0,   0, 0, 0, 18, 0, 0));
        vecs.push_back(mk(0, 0, 1, 18,  0, 0, 0, 57, 0, 0));
        vecs.push_back(mk(0, 0, 1, 57,  0, 0, 0, 174, 0, 0));
        vecs.push_back(mk(0, 0, 1, 174, 0, 0, 0, 13, 0, 0));
        vecs.push_back(mk(0, 0, 1, 13,  1, 0, 0, 42, 0, 0));
        vecs.push_back(mk(0, 0, 1, 99,  1, 0, 1, 129, 0, 1));
        vecs.push_back(mk(0, 0, 1, 129, 1, 0, 0, 134, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0,   1, 0, 1, 149, 1, 2));
        vecs.push_back(mk(0, 0, 1, 0,   1, 0, 1, 194, 1, 3));
`ifdef LCG_CHK_RESYNC_EN
        vecs.push_back(mk(0, 0, 1, 0,   0, 0, 1, 3, 1, 4));
        vecs.push_back(mk(0, 0, 1, 73,  0, 0, 0, 222, 1, 4));
        vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0, 222, 1, 4));
`else
        vecs.push_back(mk(0, 0, 1, 0,   0, 1, 1, 73, 1, 4));
        vecs.push_back(mk(0, 0, 1, 73,  0, 1, 0, 73, 1, 4));
        vecs.push_back(mk(0, 0, 0, 0,   0, 1, 0, 73, 1, 4));
`endif
        vecs.push_back(mk(1, 5, 0, 0,   0, 0, 0, 18, 0, 0));
        vecs.push_back(mk(0, 0, 1, 18,  0, 0, 0, 57, 0, 0));
        vecs.push_back(mk(0, 0, 1, 57,  0, 0, 0, 174, 0, 0));
        vecs.push_back(mk(0, 0, 1, 174, 0, 0, 0, 13, 0, 0));
        vecs.push_back(mk(0, 0, 1, 13,  1, 0, 0, 42, 0, 0));
        vecs.push_back(mk(1, 5, 1, 42,  0, 0, 0, 18, 0, 0));
        vecs.push_back(mk(0, 0, 1, 18,  0, 0, 0, 57, 0, 0));

        foreach (vecs[i]) begin
            cycle(vecs[i].st, 1, 3, vecs[i].x0, vecs[i].v, vecs[i].d, $sformatf("vec%0d", i));
            check($sformatf("vec%0d.t_locked", i), int'(locked),      int'(vecs[i].e_lk));
            check($sformatf("vec%0d.t_lost", i),   int'(lost),        int'(vecs[i].e_lost));
            check($sformatf("vec%0d.t_errp", i),   int'(err_pulse),   int'(vecs[i].e_err));
            check($sformatf("vec%0d.t_exp", i),    int'(expected),    vecs[i].e_exp);
            check($sformatf("vec%0d.t_mc", i),     int'(match_count), vecs[i].e_mc);
            check($sformatf("vec%0d.t_ec", i),     int'(err_count),   vecs[i].e_ec);
        end

        // Saturation: lock, then alternate error/match five times (r=0, b=7).
        gen = 9;
        cycle(1, 0, 7, gen, 0, 0, "sat_start");
        for (int i = 0; i < LOCK_N; i++) begin
            gen = f(gen, 0, 7);
            cycle(0, 0, 0, 0, 1, gen, "sat_acq");
        end
        check("sat.locked", int'(locked), 1);
        for (int i = 0; i < 5; i++) begin
            gen = f(gen, 0, 7);
            cycle(0, 0, 0, 0, 1, gen ^ 8'h55, "sat_err");
            gen = f(gen, 0, 7);
            cycle(0, 0, 0, 0, 1, gen, "sat_hit");
        end
        check("sat.mc2", int'(match_count2), 3);
        check("sat.ec2", int'(err_count2), 3);
        check("sat.mc16", int'(match_count), 5);
        check("sat.ec16", int'(err_count), 5);
        check("sat.locked_end", int'(locked), 1);

        // Randomized episodes: true stream with random corruption, gaps, restarts.
        for (int ep = 0; ep < 40; ep++) begin
            rr = int'($urandom_range(0, 7)); bb = int'($urandom_range(0, 255));
            xx = int'($urandom_range(0, 255));
            corrupt_pct = int'($urandom_range(0, 40));
            gen = xx;
            cycle(1, rr, bb, xx, 1'($urandom), int'($urandom_range(0, 255)), "rnd_start");
            for (int c = 0; c < 60; c++) begin
                if ($urandom_range(0, 99) < 2) begin
                    xx = int'($urandom_range(0, 255)); gen = xx;
                    cycle(1, rr, bb, xx, 1'($urandom), int'($urandom_range(0, 255)), "rnd_restart");
                end else begin
                    v = ($urandom_range(0, 99) < 75);
                    d = int'($urandom_range(0, 255));
                    if (v) begin
                        gen = f(gen, rr, bb);
                        d = ($urandom_range(0, 99) < corrupt_pct)
                            ? (gen ^ int'($urandom_range(1, 255))) : gen;
                    end
                    cycle(0, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 255)), v, d, "rnd");
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
